// File: rtl/lane_array_packer_if.sv
// Purpose: beat-in / word-out handshake bundle for lane_array_packer (optional out_par with LANE_ARR_PARITY_EN).
// Latency: none, this file only groups wires.
// Backpressure: carries in_ready/out_ready; the packer decides the policy.
interface lane_array_packer_if #(
    parameter int NLANES = 8,
    parameter int LANEW  = 4
) ();
    localparam int CNTW = $clog2(NLANES + 1);

    logic                    in_valid;
    logic                    in_ready;
    logic [LANEW-1:0]        in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [NLANES*LANEW-1:0] out_data;
    logic [CNTW-1:0]         out_count;
`ifdef LANE_ARR_PARITY_EN
    logic [NLANES-1:0]       out_par;
`endif

    // Packer side.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
`ifdef LANE_ARR_PARITY_EN
        , output out_par
`endif
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
`ifdef LANE_ARR_PARITY_EN
        , input out_par
`endif
    );
endinterface

// File: rtl/lane_array_packer.sv
// Purpose: packs LANEW-bit beats into an NLANES-lane word (beat k -> lane k); optional per-lane parity with LANE_ARR_PARITY_EN.
// Latency: final beat accepted at cycle t -> out_valid at t+1.
// Backpressure: in_ready = !out_valid | out_ready; a held word blocks input until it is taken.

// One lane register: load wins over clear so a beat arriving on the output handshake survives.
module lane_array_slot #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         clr,
    input  logic [W-1:0] d,
`ifdef LANE_ARR_PARITY_EN
    output logic         par,
`endif
    output logic [W-1:0] q
);
    logic [W-1:0] q_d;
`ifdef LANE_ARR_PARITY_EN
    logic         par_d;
`endif

    // Next lane value: load a beat, clear at word handoff, otherwise hold.
    always_comb begin
        q_d = q;
        if (ld)
            q_d = d;
        else if (clr)
            q_d = '0;
`ifdef LANE_ARR_PARITY_EN
        par_d = ^q_d;
`endif
    end

    // Lane storage, parity tracked alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
`ifdef LANE_ARR_PARITY_EN
            par <= 1'b0;
`endif
        end else begin
            q <= q_d;
`ifdef LANE_ARR_PARITY_EN
            par <= par_d;
`endif
        end
    end
endmodule

module lane_array_packer #(
    parameter int NLANES = 8,
    parameter int LANEW  = 4
) (
    input logic              clk,
    input logic              rst,
    lane_array_packer_if.slave bus
);
    localparam int CNTW = $clog2(NLANES + 1);
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NLANES - 1);

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [CNTW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0]         count_q, count_d;
    logic                    out_valid;
    logic                    accept;
    logic                    handoff;
    logic [NLANES-1:0]       lane_ld;
    logic [NLANES-1:0]       lane_clr;
    logic [NLANES*LANEW-1:0] lane_q;

    assign out_valid     = (state_q == HOLD);
    assign bus.in_ready  = !out_valid || bus.out_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_count = count_q;
    assign bus.out_data  = lane_q;
    assign accept        = bus.in_valid && bus.in_ready;
    assign handoff       = out_valid && bus.out_ready;

    // Lane strobes: the accepted beat goes to the lane under wr_ptr; every lane clears on handoff.
    always_comb begin
        lane_clr = {NLANES{handoff}};
        lane_ld  = '0;
        for (int i = 0; i < NLANES; i++)
            lane_ld[i] = accept && (wr_ptr_q == CNTW'(i));
    end

    lane_array_slot #(.W(LANEW)) lane [NLANES-1:0] (
        .clk (clk),
        .rst (rst),
        .ld  (lane_ld),
        .clr (lane_clr),
        .d   ({NLANES{bus.in_data}}),
`ifdef LANE_ARR_PARITY_EN
        .par (bus.out_par),
`endif
        .q   (lane_q)
    );

    // FILL/HOLD sequencing. In HOLD wr_ptr is 0, so a beat taken on handoff opens the next word at lane 0.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (wr_ptr_q == LAST_IDX || bus.in_last) begin
                        state_d  = HOLD;
                        count_d  = wr_ptr_q + 1'b1;
                        wr_ptr_d = '0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (handoff) begin
                    if (accept && bus.in_last) begin
                        state_d  = HOLD;
                        count_d  = CNTW'(1);
                        wr_ptr_d = '0;
                    end else begin
                        state_d  = FILL;
                        count_d  = '0;
                        wr_ptr_d = accept ? CNTW'(1) : '0;
                    end
                end
            end
            default: begin
                state_d  = FILL;
                wr_ptr_d = '0;
                count_d  = '0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_lane_array_packer.sv
// Purpose: randomized + directed check of lane_array_packer against a word-queue model.
// Latency: model completes a word at the accepting edge; DUT shows it one edge later.
// Backpressure: model derives in_ready from its own held-word queue and out_ready.
module tb_lane_array_packer;
    localparam int NL = 8;
    localparam int LW = 4;
    localparam int DW = NL * LW;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lane_array_packer_if #(.NLANES(NL), .LANEW(LW)) bus ();
    lane_array_packer #(.NLANES(NL), .LANEW(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_fail = 0;

    word_t         exp_q[$];
    logic [DW-1:0] seen_q[$];
    logic [DW-1:0] part;
    int            ptr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model + cycle compare, sampled on the falling edge.
    initial begin
        part = '0;
        ptr  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                part = '0;
                ptr  = 0;
                chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
                chk("rst_out_data", 64'(bus.out_data), 64'd0);
                chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
            end else begin
                logic mv;
                logic mrdy;
                mv   = (exp_q.size() > 0);
                mrdy = !mv || bus.out_ready;
                chk("out_valid", 64'(bus.out_valid), 64'(mv));
                chk("in_ready", 64'(bus.in_ready), 64'(mrdy));
                if (mv) begin
                    chk("out_data", 64'(bus.out_data), 64'(exp_q[0].d));
                    chk("out_count", 64'(bus.out_count), 64'(exp_q[0].c));
`ifdef LANE_ARR_PARITY_EN
                    begin
                        logic [NL-1:0] p;
                        logic [DW-1:0] w;
                        w = exp_q[0].d;
                        for (int k = 0; k < NL; k++) p[k] = ^w[k*LW +: LW];
                        chk("out_par", 64'(bus.out_par), 64'(p));
                    end
`endif
                    if (bus.out_ready) begin
                        seen_q.push_back(exp_q[0].d);
                        void'(exp_q.pop_front());
                    end
                end else begin
                    chk("idle_count", 64'(bus.out_count), 64'd0);
                end
                if (bus.in_valid && mrdy) begin
                    part[ptr*LW +: LW] = bus.in_data;
                    ptr++;
                    if (ptr == NL || bus.in_last) begin
                        exp_q.push_back('{d: part, c: ptr});
                        part = '0;
                        ptr  = 0;
                    end
                end
            end
        end
    end

    // Offer one beat and hold it until accepted (bounded).
    task automatic send(input logic [LW-1:0] d, input logic last);
        logic acc;
        int   n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        n = 0;
        acc = 1'b0;
        while (!acc) begin
            #1;
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 50) begin
                chk("send_timeout", 64'(n), 64'd0);
                acc = 1'b1;
            end
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(2);

        // Full word, held under backpressure.
        for (int i = 1; i <= 8; i++) send(LW'(i), 1'b0);
        idle();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("full_data", 64'(bus.out_data), 64'h87654321);
            chk("full_count", 64'(bus.out_count), 64'd8);
            chk("full_in_ready", 64'(bus.in_ready), 64'd0);
            cycles(1);
        end
        bus.out_ready = 1'b1;
        cycles(1);
        bus.out_ready = 1'b0;

        // Early flush.
        send(4'hA, 1'b0);
        send(4'hB, 1'b0);
        send(4'hC, 1'b1);
        idle();
        #1;
        chk("flush_data", 64'(bus.out_data), 64'h00000CBA);
        chk("flush_count", 64'(bus.out_count), 64'd3);
        bus.out_ready = 1'b1;
        cycles(2);

        // Back-to-back at full rate.
        seen_q.delete();
        for (int i = 0; i < 16; i++) send(LW'(i), 1'b0);
        idle();
        cycles(3);
        chk("b2b_words", 64'(seen_q.size()), 64'd2);
        if (seen_q.size() >= 2) begin
            chk("b2b_w0", 64'(seen_q[0]), 64'h76543210);
            chk("b2b_w1", 64'(seen_q[1]), 64'hFEDCBA98);
        end

        // Beat with in_last accepted on the handoff cycle.
        bus.out_ready = 1'b0;
        send(4'h1, 1'b0);
        send(4'h2, 1'b1);
        bus.out_ready = 1'b1;
        send(4'h5, 1'b1);
        bus.out_ready = 1'b0;
        idle();
        #1;
        chk("simul_valid", 64'(bus.out_valid), 64'd1);
        chk("simul_data", 64'(bus.out_data), 64'h00000005);
        chk("simul_count", 64'(bus.out_count), 64'd1);
        bus.out_ready = 1'b1;
        cycles(2);

        // Reset in the middle of a word.
        send(4'h7, 1'b0);
        send(4'h9, 1'b0);
        idle();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_data", 64'(bus.out_data), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        cycles(2);
        rst = 1'b0;
        cycles(1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = LW'($urandom);
            bus.in_last   = ($urandom_range(0, 5) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cycles(1);
        end
        idle();
        bus.out_ready = 1'b1;
        cycles(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
